// File: rtl/commit_trace_fifo_if.sv
// Commit-trace bundle between the core's write-back taps and the trace FIFO,
// plus the FIFO's valid/ready head port toward the trace sink.
interface commit_trace_fifo_if #(
  parameter int SEQ_W = 16
) ();

  logic             grf_we;
  logic [31:0]      grf_pc;
  logic [4:0]       grf_addr;
  logic [31:0]      grf_wdata;
  logic             dm_we;
  logic [31:0]      dm_pc;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_wdata;

  logic             out_valid;
  logic             out_ready;
  logic             out_kind;
  logic [SEQ_W-1:0] out_seq;
  logic [31:0]      out_pc;
  logic [31:0]      out_addr;
  logic [31:0]      out_data;
  logic             almost_full;
  logic             overflow;

  // master: core taps plus trace sink; slave: the trace FIFO itself
  modport master (
    output grf_we, grf_pc, grf_addr, grf_wdata,
    output dm_we, dm_pc, dm_addr, dm_wdata,
    output out_ready,
    input  out_valid, out_kind, out_seq, out_pc, out_addr, out_data,
    input  almost_full, overflow
  );

  modport slave (
    input  grf_we, grf_pc, grf_addr, grf_wdata,
    input  dm_we, dm_pc, dm_addr, dm_wdata,
    input  out_ready,
    output out_valid, out_kind, out_seq, out_pc, out_addr, out_data,
    output almost_full, overflow
  );

endinterface

// File: rtl/commit_trace_fifo.sv
// Collects retired GRF writes and DM stores in program order into a
// first-word-fall-through FIFO with per-record sequence numbers.
module commit_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16
) (
  input  logic clk,
  input  logic reset,
  commit_trace_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW:0]      count;
  logic [AW:0]      free;
  logic [AW:0]      count_next;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    wr_ptr1;
  logic [SEQ_W-1:0] seq;
  logic             almost_full_q;
  logic             overflow_q;
  logic             valid;

  logic             mem_kind [DEPTH];
  logic [SEQ_W-1:0] mem_seq  [DEPTH];
  logic [31:0]      mem_pc   [DEPTH];
  logic [31:0]      mem_addr [DEPTH];
  logic [31:0]      mem_data [DEPTH];

  logic        grf_push, dm_push, has0, has1, acc0, acc1, drop, pop;
  logic [1:0]  n_acc;
  logic        rec0_kind;
  logic [31:0] rec0_pc, rec0_addr, rec0_data;

  // The GRF write is from the older (W-stage) instruction, so it takes the
  // first slot; a lone record of either kind also takes the first slot.
  always_comb begin
    grf_push   = bus.grf_we && (bus.grf_addr != 5'd0);
    dm_push    = bus.dm_we;
    has0       = grf_push || dm_push;
    has1       = grf_push && dm_push;
    free       = DEPTH_C - count;
    acc0       = has0 && (free != '0);
    acc1       = has1 && (free >= (AW+1)'(2));
    drop       = (has0 && !acc0) || (has1 && !acc1);
    n_acc      = {1'b0, acc0} + {1'b0, acc1};
    pop        = valid && bus.out_ready;
    count_next = count + (AW+1)'(n_acc) - (AW+1)'(pop);
    wr_ptr1    = wr_ptr + AW'(1);
    if (grf_push) begin
      rec0_kind = 1'b0;
      rec0_pc   = bus.grf_pc;
      rec0_addr = {27'd0, bus.grf_addr};
      rec0_data = bus.grf_wdata;
    end else begin
      rec0_kind = 1'b1;
      rec0_pc   = bus.dm_pc;
      rec0_addr = bus.dm_addr;
      rec0_data = bus.dm_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      seq           <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      count         <= count_next;
      rd_ptr        <= rd_ptr + AW'(pop);
      wr_ptr        <= wr_ptr + AW'(n_acc);
      seq           <= seq + SEQ_W'(n_acc);
      almost_full_q <= (DEPTH_C - count_next) < (AW+1)'(2);
      overflow_q    <= overflow_q | drop;
    end
  end

  // Storage needs no reset: the head fields are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (reset && acc0) begin
      mem_kind[wr_ptr] <= rec0_kind;
      mem_seq[wr_ptr]  <= seq;
      mem_pc[wr_ptr]   <= rec0_pc;
      mem_addr[wr_ptr] <= rec0_addr;
      mem_data[wr_ptr] <= rec0_data;
    end
    if (reset && acc1) begin
      mem_kind[wr_ptr1] <= 1'b1;
      mem_seq[wr_ptr1]  <= seq + SEQ_W'(1);
      mem_pc[wr_ptr1]   <= bus.dm_pc;
      mem_addr[wr_ptr1] <= bus.dm_addr;
      mem_data[wr_ptr1] <= bus.dm_wdata;
    end
  end

  assign valid           = (count != '0);
  assign bus.out_valid   = valid;
  assign bus.out_kind    = valid ? mem_kind[rd_ptr] : 1'b0;
  assign bus.out_seq     = valid ? mem_seq[rd_ptr]  : '0;
  assign bus.out_pc      = valid ? mem_pc[rd_ptr]   : '0;
  assign bus.out_addr    = valid ? mem_addr[rd_ptr] : '0;
  assign bus.out_data    = valid ? mem_data[rd_ptr] : '0;
  assign bus.almost_full = almost_full_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo: ordering, $0 filtering, fill/overflow,
// backpressure stability and reset behaviour with hand-computed expectations.
module tb_commit_trace_fifo;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  commit_trace_fifo_if #(.SEQ_W(16)) bus ();

  commit_trace_fifo #(.DEPTH(16), .SEQ_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Inputs change 1 ns after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.grf_we    = 1'b0;
    bus.grf_pc    = '0;
    bus.grf_addr  = '0;
    bus.grf_wdata = '0;
    bus.dm_we     = 1'b0;
    bus.dm_pc     = '0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
  endtask

  task automatic applyStimulus(input logic gwe, input logic [31:0] gpc,
                               input logic [4:0] gaddr, input logic [31:0] gdata,
                               input logic dwe, input logic [31:0] dpc,
                               input logic [31:0] daddr, input logic [31:0] ddata);
    bus.grf_we    = gwe;
    bus.grf_pc    = gpc;
    bus.grf_addr  = gaddr;
    bus.grf_wdata = gdata;
    bus.dm_we     = dwe;
    bus.dm_pc     = dpc;
    bus.dm_addr   = daddr;
    bus.dm_wdata  = ddata;
    tick();
    clearInputs();
  endtask

  task automatic doReset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic checkHead(input string tag, input logic kind, input logic [15:0] seq,
                           input logic [31:0] pc, input logic [31:0] addr,
                           input logic [31:0] data);
    checkOutput({tag, ".valid"}, 64'(bus.out_valid), 64'(1));
    checkOutput({tag, ".kind"},  64'(bus.out_kind),  64'(kind));
    checkOutput({tag, ".seq"},   64'(bus.out_seq),   64'(seq));
    checkOutput({tag, ".pc"},    64'(bus.out_pc),    64'(pc));
    checkOutput({tag, ".addr"},  64'(bus.out_addr),  64'(addr));
    checkOutput({tag, ".data"},  64'(bus.out_data),  64'(data));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.out_ready = 1'b1;
    clearInputs();
    tick();
    tick();

    checkOutput("rst.valid", 64'(bus.out_valid),   64'(0));
    checkOutput("rst.af",    64'(bus.almost_full), 64'(0));
    checkOutput("rst.ovf",   64'(bus.overflow),    64'(0));
    checkOutput("rst.pc",    64'(bus.out_pc),      64'(0));
    checkOutput("rst.seq",   64'(bus.out_seq),     64'(0));
    reset = 1'b1;
    tick();

    // Single GRF write
    applyStimulus(1'b1, 32'h3000, 5'd8, 32'h12345678, 1'b0, 0, 0, 0);
    checkHead("grf", 1'b0, 16'd0, 32'h3000, 32'd8, 32'h12345678);
    tick();
    checkOutput("grf.after", 64'(bus.out_valid), 64'(0));

    // $0 writes are discarded and consume no sequence number
    doReset();
    applyStimulus(1'b1, 32'h300c, 5'd0, 32'hFFFF, 1'b0, 0, 0, 0);
    checkOutput("zero.valid", 64'(bus.out_valid), 64'(0));
    applyStimulus(1'b1, 32'h3010, 5'd1, 32'hAA, 1'b0, 0, 0, 0);
    checkHead("zero.r1", 1'b0, 16'd0, 32'h3010, 32'd1, 32'hAA);
    tick();
    checkOutput("zero.after", 64'(bus.out_valid), 64'(0));

    // Simultaneous GRF + DM: GRF first
    doReset();
    applyStimulus(1'b1, 32'h3004, 5'd2, 32'd5, 1'b1, 32'h3008, 32'h10, 32'd7);
    checkHead("dual.grf", 1'b0, 16'd0, 32'h3004, 32'd2, 32'd5);
    tick();
    checkHead("dual.dm", 1'b1, 16'd1, 32'h3008, 32'h10, 32'd7);
    tick();
    checkOutput("dual.after", 64'(bus.out_valid), 64'(0));

    // Fill with 8 dual pushes, then one dropped dual push
    doReset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h4000 + 32'(8*i), 5'(i+1), 32'(2*i),
                    1'b1, 32'h4004 + 32'(8*i), 32'h100 + 32'(4*i), 32'(2*i+1));
      if (i == 6) checkOutput("fill.af14", 64'(bus.almost_full), 64'(0));
    end
    checkOutput("fill.af16",  64'(bus.almost_full), 64'(1));
    checkOutput("fill.ovf0",  64'(bus.overflow),    64'(0));
    applyStimulus(1'b1, 32'h5000, 5'd9, 32'h99, 1'b1, 32'h5004, 32'h200, 32'h98);
    checkOutput("fill.ovf1",  64'(bus.overflow),    64'(1));
    checkOutput("fill.af",    64'(bus.almost_full), 64'(1));
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("drain%0d.valid", k), 64'(bus.out_valid), 64'(1));
      checkOutput($sformatf("drain%0d.seq", k),   64'(bus.out_seq),   64'(k));
      checkOutput($sformatf("drain%0d.kind", k),  64'(bus.out_kind),  64'(k % 2));
      checkOutput($sformatf("drain%0d.pc", k),    64'(bus.out_pc),    64'(32'h4000 + 4*k));
      checkOutput($sformatf("drain%0d.data", k),  64'(bus.out_data),  64'(k));
      tick();
    end
    checkOutput("drain.empty", 64'(bus.out_valid),   64'(0));
    checkOutput("drain.af",    64'(bus.almost_full), 64'(0));
    checkOutput("drain.ovf",   64'(bus.overflow),    64'(1));

    // Reset mid-backpressure with 5 buffered records and a push in the reset cycle
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 32'h6000, 5'd3, 32'd1, 1'b1, 32'h6004, 32'h40, 32'd2);
    applyStimulus(1'b1, 32'h6008, 5'd4, 32'd3, 1'b1, 32'h600c, 32'h44, 32'd4);
    applyStimulus(1'b1, 32'h6010, 5'd5, 32'd5, 1'b0, 0, 0, 0);
    checkHead("mid.head", 1'b0, 16'd16, 32'h6000, 32'd3, 32'd1);
    reset = 1'b0;
    applyStimulus(1'b1, 32'h6014, 5'd6, 32'd6, 1'b1, 32'h6018, 32'h48, 32'd7);
    reset = 1'b1;
    checkOutput("mid.valid", 64'(bus.out_valid), 64'(0));
    checkOutput("mid.ovf",   64'(bus.overflow),  64'(0));
    checkOutput("mid.af",    64'(bus.almost_full), 64'(0));
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 32'h7000, 5'd7, 32'h77, 1'b0, 0, 0, 0);
    checkHead("mid.restart", 1'b0, 16'd0, 32'h7000, 32'd7, 32'h77);
    tick();

    // Backpressure: head fields stay stable, then one pop per cycle
    doReset();
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 32'h5000, 5'd3, 32'hDEAD, 1'b1, 32'h5004, 32'h20, 32'hBEEF);
    applyStimulus(1'b1, 32'h5008, 5'd4, 32'hCAFE, 1'b0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      checkHead($sformatf("bp%0d", c), 1'b0, 16'd0, 32'h5000, 32'd3, 32'hDEAD);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    checkHead("bp.pop1", 1'b1, 16'd1, 32'h5004, 32'h20, 32'hBEEF);
    tick();
    checkHead("bp.pop2", 1'b0, 16'd2, 32'h5008, 32'd4, 32'hCAFE);
    tick();
    checkOutput("bp.empty", 64'(bus.out_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/commit_trace_fifo.md
# commit_trace_fifo

Synthesizable commit-trace collector attached to the write-back side of the pipelined MIPS core. It captures every architectural register-file write and every data-memory store the core retires, orders them into program order, and buffers them in a FIFO. It then presents the records one at a time on a valid/ready port to a trace sink, which is either a UART/host bridge or the bench checker. The core and bench only drive clock and reset; this block carries the core's architectural results outward.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥ 4
- SEQ_W, 16, width of the per-record sequence number

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (reset = 0 clears state on the clk edge)
- grf_we  in  1  W-stage register write this cycle
- grf_pc  in  32  PC of the writing instruction
- grf_addr  in  5  destination register
- grf_wdata  in  32  value written
- dm_we  in  1  M-stage store this cycle
- dm_pc  in  32  PC of the store
- dm_addr  in  32  byte address, word-aligned
- dm_wdata  in  32  stored word
- out_valid  out  1  head record available
- out_ready  in  1  sink accepts the head record
- out_kind  out  1  0 = GRF write, 1 = DM store
- out_seq  out  SEQ_W  record sequence number
- out_pc  out  32  record PC
- out_addr  out  32  zero-extended grf_addr, or dm_addr
- out_data  out  32  written data
- almost_full  out  1  free slots < 2; the core should freeze
- overflow  out  1  sticky, a record was dropped

## Operation
- Push candidates each cycle:
  - GRF record if grf_we = 1 and grf_addr ≠ 0. Writes to $0 are silently discarded and consume no sequence number.
  - DM record if dm_we = 1.
- Simultaneous GRF and DM: the GRF record belongs to the older instruction (W stage), so it is pushed first with seq = s. The DM record is pushed second with seq = s+1.
- Acceptance uses free = DEPTH − count, where count is the value at the start of the cycle. A pop in the same cycle does not create room.
  - free ≥ 2: both records accepted.
  - free = 1: GRF accepted, DM dropped.
  - free = 0: all records dropped.
  - Any drop sets overflow, which stays set until reset.
- Dropped records do not advance seq. seq increments by 1 per accepted record and wraps modulo 2^SEQ_W.
- Pop occurs when out_valid && out_ready.
- While out_valid = 1 and out_ready = 0, all out_* fields hold stable.
- count update: count' = count + accepted − popped, with accepted ∈ {0, 1, 2} and popped ∈ {0, 1}. count never exceeds DEPTH.
- Read and write pointers are log2(DEPTH) bits wide and wrap naturally.
- almost_full = (DEPTH − count' < 2). It is registered.

## Timing
- Reset (reset = 0 at an edge) sets:
  - count, pointers and seq to 0
  - out_valid, almost_full and overflow to 0
  - out_kind, out_seq, out_pc, out_addr and out_data to 0
- Reset overrides every push and pop in the same cycle. Buffered records are discarded, including a reset asserted mid-backpressure.
- Latency: a record pushed at edge N appears at the head with out_valid = 1 after edge N, provided the FIFO was empty. This is first-word-fall-through with a one-cycle latency.
- Steady state: one record per cycle out when out_ready is held high. Two-record pushes therefore accumulate.
- Empty FIFO with a push and out_ready = 1 in the same cycle: there is no bypass. The record is presented the next cycle.
- almost_full and overflow change only on clk edges.

## Test plan
- GRF write only:
  - Stimulus: reset released, out_ready = 1, one cycle of grf_we = 1, pc = 0x00003000, addr = 8, wdata = 0x12345678.
  - Response: the next cycle shows out_valid = 1, kind = 0, seq = 0, pc = 0x3000, addr = 8, data = 0x12345678. out_valid = 0 the cycle after.
- $0 filter:
  - Stimulus: grf_we = 1 with addr = 0, then a GRF write to addr 1.
  - Response: exactly one record appears, with addr = 1 and seq = 0.
- Simultaneous events:
  - Stimulus: grf_we = 1 (pc 0x3004, $2 = 5) and dm_we = 1 (pc 0x3008, addr 0x10, data 7) in the same cycle, out_ready = 1.
  - Response: the GRF record with seq = 0, then the DM record with seq = 1, on consecutive cycles.
- Fill and overflow (DEPTH = 16):
  - Stimulus: out_ready = 0, push 8 dual-record cycles (16 records), then one more dual push.
  - Response: almost_full = 1 after count reaches 15. On the extra push both records are dropped and overflow = 1. Draining yields seq 0..15 in order.
- Backpressure stability:
  - Stimulus: hold out_ready = 0 for 5 cycles with a record at the head.
  - Response: all out_* fields are unchanged. Raising out_ready pops exactly one record per cycle.
- Reset mid-operation:
  - Stimulus: 5 records buffered, reset = 0 for one edge.
  - Response: out_valid = 0, overflow = 0 and seq restarts at 0 on the next accepted record.
